// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic        err;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction fetch port and a data port,
// with data priority, bounded instruction starvation and a per-grant timeout.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);

  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam int GW = ($clog2(TIMEOUT) > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [GW-1:0] GRANT_LAST = GW'(TIMEOUT - 1);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [1:0]    RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [GW-1:0] grant_cnt;

  logic d_req;
  logic i_act;
  logic d_act;
  logic grant_act;
  logic ram_access;
  logic ram_error;
  logic timeout;
  logic release_grant;
  logic starve_hit;

  // A grant is only live while its requester still asks; dropping the request
  // kills the RAM enables in the same cycle.
  assign d_req         = bus.dREN | bus.dWEN;
  assign i_act         = (state == IGNT) & bus.iREN;
  assign d_act         = (state == DGNT) & d_req;
  assign grant_act     = i_act | d_act;
  assign ram_access    = (bus.ramstate == RAM_ACCESS);
  assign ram_error     = (bus.ramstate == RAM_ERROR);
  assign timeout       = grant_act & ~ram_access & (grant_cnt == GRANT_LAST);
  assign release_grant = ~grant_act | ram_access | ram_error | timeout;
  assign starve_hit    = (starve_cnt == STARVE_LIM);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      grant_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          grant_cnt <= '0;
          if (d_req && !(bus.iREN && starve_hit)) begin
            state <= DGNT;
            // starve_hit with iREN set diverts to IGNT, so this never overflows.
            starve_cnt <= bus.iREN ? starve_cnt + 1'b1 : '0;
          end else if (bus.iREN) begin
            state      <= IGNT;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        IGNT, DGNT: begin
          if (release_grant) state <= IDLE;
          else               grant_cnt <= grant_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the conditional logic so the
  // combinational block can never infer a latch.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (i_act) begin
      bus.ramREN  = 1'b1;
      bus.ramaddr = bus.iaddr;
    end else if (d_act) begin
      bus.ramaddr  = bus.daddr;
      bus.ramstore = bus.dstore;
      bus.ramWEN   = bus.dWEN;
      bus.ramREN   = ~bus.dWEN;
    end
  end

  assign bus.iload = (state == IGNT) ? bus.ramload : '0;
  assign bus.dload = (state == DGNT) ? bus.ramload : '0;
  assign bus.iwait = bus.iREN & ~((state == IGNT) & ram_access);
  assign bus.dwait = d_req & ~((state == DGNT) & ram_access);
  assign bus.err   = grant_act & (ram_error | timeout);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: STARVE_MAX, default 4, max consecutive data grants while an instruction request waits; TIMEOUT, default 16, max cycles one grant may wait for ACCESS.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 iREN  in  1  instruction fetch request.
REQ-005 iaddr  in  32  fetch address.
REQ-006 iload  out  32  fetch data.
REQ-007 iwait  out  1  fetch not complete.
REQ-008 dREN  in  1  data read request.
REQ-009 dWEN  in  1  data write request.
REQ-010 daddr  in  32  data address.
REQ-011 dstore  in  32  write data.
REQ-012 dload  out  32  read data.
REQ-013 dwait  out  1  data access not complete.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-020 err  out  1  one-cycle pulse on ERROR or timeout abort.

Function
REQ-021 FSM states: IDLE, IGNT, DGNT.
REQ-022 IDLE, no request -> IDLE; ram enables 0, ramaddr/ramstore 0.
REQ-023 IDLE, only (dREN|dWEN) -> DGNT; only iREN -> IGNT.
REQ-024 IDLE, both pending -> DGNT, unless starve_cnt == STARVE_MAX -> IGNT.
REQ-025 starve_cnt (3+ bits, saturating at STARVE_MAX): +1 on each entry to DGNT while iREN=1; cleared on entry to IGNT or when iREN=0 in IDLE.
REQ-026 IGNT drives ramREN=1, ramWEN=0, ramaddr=iaddr.
REQ-027 DGNT drives ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write beats read when both set); else ramREN=1.
REQ-028 Completion: in grant state with ramstate==ACCESS, granted requester's wait=0 combinationally that cycle; next state IDLE.
REQ-029 iload = ramload in IGNT, else 0; dload = ramload in DGNT, else 0.
REQ-030 iwait = iREN & ~(IGNT & ACCESS); dwait = (dREN|dWEN) & ~(DGNT & ACCESS).
REQ-031 Min latency request->completion: 2 cycles (IDLE decision edge, then ACCESS in grant state); one idle cycle between back-to-back grants.
REQ-032 Requester drops its request in its grant state -> IDLE next cycle; ram enables 0 from that cycle (combinational on request), no err.
REQ-033 ramstate==ERROR in grant state -> err=1 that cycle, wait stays 1, IDLE next cycle; request re-arbitrated (retry).
REQ-034 grant_cnt cleared on grant entry, +1 per grant cycle without ACCESS; reaching TIMEOUT-1 -> err=1, IDLE next cycle.
REQ-035 Address/data change mid-grant passes to RAM unregistered; no grant switch until IDLE.
REQ-036 BUSY or FREE in grant state -> hold state, waits asserted.

Reset
REQ-037 nRST=0 asynchronously: state IDLE, starve_cnt=0, grant_cnt=0, err=0; ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
REQ-038 Reset mid-grant aborts the transfer; RAM enables drop immediately without clock; waits follow REQ-030 from IDLE.
REQ-039 First arbitration on first rising edge after nRST deasserts.

Verification
REQ-040 iREN=1, iaddr=0x100, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> IGNT, ramREN=1, ramaddr=0x100; iwait=0 and iload=0xDEADBEEF in ACCESS cycle only.
REQ-041 iREN=1 and dWEN=1 same cycle, daddr=0x200, dstore=0x55 -> DGNT first, ramWEN=1, ramstore=0x55; after completion and one IDLE cycle, IGNT.
REQ-042 iREN held, dREN re-asserted continuously, STARVE_MAX=4 -> exactly 4 data grants, then IGNT; starve_cnt=0 after.
REQ-043 DGNT, ramstate=ERROR one cycle -> err pulse 1 cycle, dwait=1, IDLE, then DGNT retry completing normally.
REQ-044 IGNT, ramstate held BUSY 16 cycles -> err pulse on 16th cycle, IDLE next; nRST pulsed mid-DGNT -> ramWEN=0 immediately, state IDLE.
